// File: rtl/riscv_pkg.sv
// riscv_pkg: immediate-type codes, opcodes, NOP and fetch FSM encoding shared by fetch, immediate unit and decoder
package riscv_pkg;
  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } imm_type_e;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory, redirect and downstream instruction handshake signals
interface instruction_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [24:0] imm_bus_o;
  logic [2:0]  imm_type_o;
  logic        illegal_o;
  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, imm_bus_o, imm_type_o, illegal_o,
    input  imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, imm_bus_o, imm_type_o, illegal_o,
    output imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/opcode_imm_decoder.sv
// opcode_imm_decoder: maps a 7-bit opcode to its immediate type and flags undecodable opcodes
module opcode_imm_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_type_o,
  output logic       illegal_o
);
  always_comb begin
    imm_type_o = R_TYPE;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_OP:                               imm_type_o = R_TYPE;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: imm_type_o = I_TYPE;
      OP_STORE:                            imm_type_o = S_TYPE;
      OP_BRANCH:                           imm_type_o = B_TYPE;
      OP_LUI, OP_AUIPC:                    imm_type_o = U_TYPE;
      OP_JAL:                              imm_type_o = J_TYPE;
      default:                             illegal_o  = 1'b1;
    endcase
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding req/ack fetch into an instruction register with valid/ready output and redirect
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic clk,
  input logic reset,
  instruction_fetch_unit_if.master bus
);
  fetch_state_e state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, instr_q, instr_d, pc_q, pc_d;
  logic take, fire, unused;
  assign unused = ^bus.redirect_pc_i[1:0];
  // a redirect wins over a same-cycle ack, so the returned word is dropped
  always_comb begin
    take       = bus.redirect_i && state_q != IDLE;
    fire       = state_q == FETCH && bus.imem_ack_i && !bus.redirect_i;
    state_d    = fire ? HOLD : (state_q == HOLD && !take && !bus.instr_ready_i) ? HOLD : FETCH;
    fetch_pc_d = take ? {bus.redirect_pc_i[31:2], 2'b00} : fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    instr_d    = fire ? bus.imem_rdata_i : instr_q;
    pc_d       = fire ? fetch_pc_q : pc_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= NOP;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  assign bus.imem_req_o    = state_q == FETCH;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = state_q == HOLD;
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.imm_bus_o     = instr_q[31:7];
  opcode_imm_decoder u_dec (
    .opcode_i   (instr_q[6:0]),
    .imm_type_o (bus.imm_type_o),
    .illegal_o  (bus.illegal_o)
  );
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage placed directly upstream of the immediate unit and the decoder. It holds the program counter, performs a request/acknowledge fetch from instruction memory and latches the returned word into an instruction register. It presents that word downstream with a valid/ready handshake, together with the 25-bit immediate bus and the 3-bit immediate-type code that the immediate unit consumes. Branch and jump targets re-steer it through a redirect port.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- imem_req_o  out  1  fetch request to instruction memory.
- imem_addr_o  out  32  fetch address; bits [1:0] always 0.
- imem_ack_i  in  1  memory returns imem_rdata_i for the current imem_addr_o this cycle.
- imem_rdata_i  in  32  fetched instruction word.
- redirect_i  in  1  pipeline redirect (taken branch/jump).
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and treated as 0.
- instr_valid_o  out  1  instr_o, pc_o, imm_bus_o and imm_type_o are valid.
- instr_ready_i  in  1  consumer accepts the instruction.
- instr_o  out  32  instruction register.
- pc_o  out  32  address of instr_o.
- imm_bus_o  out  25  instr_o[31:7], the immediate unit's instruction bus.
- imm_type_o  out  3  immediate type: R=0, I=1, S=2, B=3, U=4, J=5.
- illegal_o  out  1  instr_o opcode is not decodable.

## Operation
- Internal state:
  - fetch_pc (32 bits).
  - FSM with states IDLE, FETCH, HOLD.
- Reset values:
  - FSM is IDLE; fetch_pc is RESET_PC.
  - imem_req_o = 0 and imem_addr_o = RESET_PC.
  - instr_valid_o = 0.
  - instr_o = 32'h0000_0013 (NOP), so imm_type_o = 1, imm_bus_o = 0, illegal_o = 0.
  - pc_o = RESET_PC.
- IDLE: moves to FETCH on the first posedge after reset deasserts.
- FETCH:
  - imem_req_o = 1 and imem_addr_o = fetch_pc.
  - On imem_ack_i: instr_o <= imem_rdata_i, pc_o <= fetch_pc, fetch_pc <= fetch_pc + 4, go to HOLD.
- HOLD:
  - instr_valid_o = 1 and imem_req_o = 0.
  - On instr_ready_i: go to FETCH.
  - Outputs are stable while valid is high and ready is low.
- Only one fetch is ever outstanding; ack is ignored outside FETCH.
- Redirect has the highest priority in FETCH or HOLD:
  - Updates: fetch_pc <= {redirect_pc_i[31:2], 2'b00}; state <= FETCH; instr_valid_o drops next cycle.
  - An ack arriving in the same cycle as a redirect is discarded: instr_o and pc_o are unchanged.
  - Redirect together with valid&ready in HOLD counts as a completed handshake, then the redirect takes effect.
  - Redirect in IDLE is ignored.
- fetch_pc increments modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- imm_type_o and illegal_o are combinational from instr_o[6:0]:
  - 0110011 → R.
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → imm_type_o = 0 and illegal_o = 1.
- Reset asserted mid-fetch or mid-hold immediately forces all reset values; no partial update survives.

## Timing
- Ack in cycle N → instr_valid_o high from cycle N+1.
- Handshake in cycle M → imem_req_o high in cycle M+1.
- Best-case throughput: one instruction per 2 cycles, with zero-wait memory and ready held high.
- Redirect in cycle R → imem_addr_o = target in cycle R+1.
- imem_req_o, imem_addr_o and instr_valid_o are decoded from registered state only; no combinational path from inputs.
- imm_bus_o, imm_type_o and illegal_o are combinational from instr_o only.

## Structure
- Shared package riscv_pkg holds:
  - Immediate-type codes R_TYPE..J_TYPE.
  - Opcode constants.
  - The NOP constant 32'h0000_0013.
  - The FSM state encoding.
- The immediate unit takes its type codes from this package.
- One sub-module, opcode_imm_decoder: combinational instr[6:0] → imm_type_o and illegal_o; reused by the decoder.

## Test plan
- Reset release, zero-wait memory, ready=1, words 0x00500093, 0x00A02023 → imem_addr_o 0x00400000 then 0x00400004; imm_type_o 1 then 2; pc_o follows the addresses.
- Ack delayed 3 cycles with ready held low 4 cycles → imem_req_o stays high until ack; instr_o and valid stay stable until ready; no second request while in HOLD.
- Redirect to 0x00400103 in the same cycle as ack → returned word discarded; next imem_addr_o = 0x00400100.
- fetch_pc = 0xFFFFFFFC fetch completes → next imem_addr_o = 0x00000000.
- Word 0xFFFFFFFF → illegal_o = 1 and imm_type_o = 0; word 0x0000006F → imm_type_o = 5 and imm_bus_o = 0.
- Reset asserted while in HOLD → outputs return to reset values asynchronously; first request after release is at RESET_PC.
